dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache. It is the responder to the memory access stage's read/write/busywait request interface.
- Sits between the memory access stage and the main data memory.
- Provides a flush command so the OS context-switch path can write back every dirty line and invalidate the cache before the cache is switched.

Parameters:
- NUM_LINES, 8, number of cache lines (power of 2); index width IW = log2(NUM_LINES)
- WORDS_PER_BLOCK, 4, 32-bit words per line; block = 128 bits
- TAG_W, 32-4-IW (=25), tag width; address split is tag[31:4+IW], index[4+IW-1:4], word[3:2]; address bits [1:0] are ignored

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- read  in  1  CPU read request, held until busywait low
- write  in  1  CPU write request, held until busywait low
- address  in  32  CPU byte address
- writedata  in  32  CPU store word
- readdata  out  32  load word, valid when read=1 and busywait=0
- busywait  out  1  stall to CPU
- flush  in  1  one-cycle pulse: write back dirty lines, invalidate all lines
- flush_done  out  1  one-cycle pulse when the flush completes
- mem_read  out  1  block fetch request
- mem_write  out  1  block writeback request
- mem_address  out  28  block address (byte address [31:4])
- mem_writedata  out  128  block to write back
- mem_readdata  in  128  fetched block
- mem_busywait  in  1  memory busy; a transfer completes at the edge where the request is high and mem_busywait=0

Behaviour:
- Reset, synchronous and active-high (already decided): clears all valid and dirty bits and sets state to IDLE. At reset: busywait=0, flush_done=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0, readdata=0. Reset mid-transfer aborts; mem_read/mem_write are low from the reset edge.
- States: IDLE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- Hit = valid[index] and tag match.
- IDLE, read hit: readdata driven combinationally from the selected word; busywait=0; zero stall cycles.
- IDLE, write hit: busywait=0; word written and dirty set at the clock edge.
- IDLE, miss (read or write): busywait=1 combinationally in the same cycle. Next state is WRITEBACK if the victim is valid and dirty, else ALLOCATE.
- WRITEBACK: mem_write=1, mem_address={victim tag, index}, mem_writedata=victim block. On completion, go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_address=address[31:4]. On completion: install block, set valid, set tag, clear dirty, return to IDLE. The access is then a hit, so the stall lasts until the cycle after refill.
- busywait=1 in every state except IDLE, and in IDLE on a miss.
- read and write both high: write takes priority and readdata is undefined.
- Flush:
  - Accepted only in IDLE. If a CPU request is present in the same cycle, the request is serviced first and the flush is latched pending.
  - FLUSH_SCAN walks index 0..NUM_LINES-1, one index per cycle. A dirty valid line goes to FLUSH_WB (mem_write of that line), then scanning resumes at the next index.
  - After the last index: clear all valid and dirty bits, pulse flush_done for one cycle, return to IDLE.
  - busywait=1 for the whole flush.
  - A flush pulse arriving during a flush is ignored.
- Memory-side outputs are registered-stable while mem_busywait=1. mem_read and mem_write are never high together.

Decomposition:
- Shared package dcache_pkg:
  - state enum
  - address-field slicing constants (offset, index and tag positions)
  - block width constant
- Natural sub-module: dcache_array, holding the tag/valid/dirty/data storage. It has a combinational read port and one synchronous write port (word write or full-block fill), plus a clear-all input.
- The controller FSM stays in dcache_controller.

Test Plan:
- Cold read miss: memory model with 3-cycle latency.
  - Stimulus: read 0x0000_0040; memory block = {0xD,0xC,0xB,0xA}, word 0 = 0xA.
  - Required: busywait high, one mem_read with mem_address=0x0000004, then readdata=0xA with busywait low.
  - Follow-up: read 0x44 hits with 0 stall and returns 0xB.
- Write hit then conflicting read (dirty eviction):
  - Stimulus: write 0x40 <= 0x1234_5678, then read 0x0000_00C0 (same index 4, different tag).
  - Required: mem_write of block 0x0000004 with word0=0x12345678, then mem_read 0x000000C, then data returned.
- Write miss allocate:
  - Stimulus: write 0x100 <= 0xCAFEF00D into a clean victim.
  - Required: no mem_write; one mem_read 0x0000010; line dirty.
  - Follow-up: read 0x100 returns 0xCAFEF00D at 0 stall.
- Flush with dirty lines at indices 1 and 6:
  - Required: exactly two mem_writes, in index order; flush_done pulses once; busywait high throughout.
  - Follow-up: read of a previously cached address misses.
- Reset mid-ALLOCATE:
  - Stimulus: assert reset while mem_read=1 and mem_busywait=1.
  - Required: the next edge shows mem_read=0, busywait=0, state IDLE; a subsequent read of the same address misses.
- Flush pulse coincident with a read miss:
  - Required: the miss completes first, then the flush runs; flush_done asserts after the refill.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared constants and types for the direct-mapped write-back data cache.
// Address split: tag[31:7] | index[6:4] | word[3:2] | byte[1:0].
package dcache_pkg;

  localparam int NUM_LINES       = 8;
  localparam int IW              = $clog2(NUM_LINES);
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = 32 * WORDS_PER_BLOCK;
  localparam int WORD_LSB        = 2;
  localparam int IDX_LSB         = 4;
  localparam int TAG_LSB         = IDX_LSB + IW;
  localparam int TAG_W           = 32 - TAG_LSB;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_WRITEBACK  = 3'd1;
  localparam state_t S_ALLOCATE   = 3'd2;
  localparam state_t S_FLUSH_SCAN = 3'd3;
  localparam state_t S_FLUSH_WB   = 3'd4;

  function automatic logic [31:0] word_of(
    input logic [BLOCK_W-1:0] blk,
    input logic [1:0]         w
  );
    return blk[{w, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port,
// one synchronous write port (word store or block fill), clear-all.
module dcache_array
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               i_clr,
  input  logic [IW-1:0]      i_idx,
  input  logic               i_we,
  input  logic [1:0]         i_wsel,
  input  logic [31:0]        i_wdata,
  input  logic               i_fill,
  input  logic [TAG_W-1:0]   i_fill_tag,
  input  logic [BLOCK_W-1:0] i_fill_data,
  input  logic [IW-1:0]      i_rd_idx,
  output logic               o_valid,
  output logic               o_dirty,
  output logic [TAG_W-1:0]   o_tag,
  output logic [BLOCK_W-1:0] o_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [BLOCK_W-1:0]   r_data [NUM_LINES];

  // Line state bits; clear wins over fill, fill wins over store.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag and data payload, no reset needed behind the valid bits.
  always_ff @(posedge clk) begin
    if (i_fill) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_we) begin
      r_data[i_idx][{i_wsel, 5'b0} +: 32] <= i_wdata;
    end
  end

  // Combinational lookup of the selected line.
  always_comb begin
    o_valid = r_valid[i_rd_idx];
    o_dirty = r_dirty[i_rd_idx];
    o_tag   = r_tag[i_rd_idx];
    o_data  = r_data[i_rd_idx];
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache controller
// with a whole-cache flush for context switches.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        address,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               busywait,
  input  logic               flush,
  output logic               flush_done,
  output logic               mem_read,
  output logic               mem_write,
  output logic [31-IDX_LSB:0] mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata,
  input  logic               mem_busywait
);

  localparam logic [IW-1:0] LAST_IDX = '1;

  state_t r_state, w_state_nxt;
  logic [IW-1:0] r_scan_idx, w_scan_nxt;
  logic r_flush_pend, w_pend_nxt;
  logic r_flush_done, w_done_nxt;

  logic [IW-1:0]      w_idx, w_rd_idx;
  logic [TAG_W-1:0]   w_tag, w_line_tag;
  logic [1:0]         w_wsel;
  logic [BLOCK_W-1:0] w_blk;
  logic w_valid, w_dirty, w_hit, w_req;
  logic w_idle, w_last, w_scanning;
  logic w_we, w_fill, w_flush_clr;
  logic w_unused_addr;

  assign w_idx  = address[TAG_LSB-1:IDX_LSB];
  assign w_tag  = address[31:TAG_LSB];
  assign w_wsel = address[IDX_LSB-1:WORD_LSB];
  assign w_unused_addr = ^address[WORD_LSB-1:0];

  assign w_idle     = (r_state == S_IDLE);
  assign w_scanning = (r_state == S_FLUSH_SCAN) ||
                      (r_state == S_FLUSH_WB);
  assign w_rd_idx   = w_scanning ? r_scan_idx : w_idx;
  assign w_last     = (r_scan_idx == LAST_IDX);
  assign w_req      = read | write;
  assign w_hit      = w_valid && (w_line_tag == w_tag);

  dcache_array u_array (
    .clk         (clk),
    .i_clr       (reset | w_flush_clr),
    .i_idx       (w_idx),
    .i_we        (w_we & ~reset),
    .i_wsel      (w_wsel),
    .i_wdata     (writedata),
    .i_fill      (w_fill & ~reset),
    .i_fill_tag  (w_tag),
    .i_fill_data (mem_readdata),
    .i_rd_idx    (w_rd_idx),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_data      (w_blk)
  );

  // Next-state, array write enables and flush bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_scan_nxt  = r_scan_idx;
    w_pend_nxt  = r_flush_pend;
    w_done_nxt  = 1'b0;
    w_we        = 1'b0;
    w_fill      = 1'b0;
    w_flush_clr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_we = write;
            if (flush || r_flush_pend) begin
              w_state_nxt = S_FLUSH_SCAN;
              w_pend_nxt  = 1'b0;
              w_scan_nxt  = '0;
            end
          end else begin
            if (flush) w_pend_nxt = 1'b1;
            w_state_nxt = (w_valid && w_dirty) ?
                          S_WRITEBACK : S_ALLOCATE;
          end
        end else if (flush || r_flush_pend) begin
          w_state_nxt = S_FLUSH_SCAN;
          w_pend_nxt  = 1'b0;
          w_scan_nxt  = '0;
        end
      end
      S_WRITEBACK: begin
        if (!mem_busywait) w_state_nxt = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        if (!mem_busywait) begin
          w_fill      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_FLUSH_SCAN: begin
        if (w_valid && w_dirty) begin
          w_state_nxt = S_FLUSH_WB;
        end else if (w_last) begin
          w_flush_clr = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_scan_nxt = r_scan_idx + 1'b1;
        end
      end
      S_FLUSH_WB: begin
        if (!mem_busywait) begin
          if (w_last) begin
            w_flush_clr = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_scan_nxt  = r_scan_idx + 1'b1;
            w_state_nxt = S_FLUSH_SCAN;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_scan_idx   <= '0;
      r_flush_pend <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_scan_idx   <= w_scan_nxt;
      r_flush_pend <= w_pend_nxt;
      r_flush_done <= w_done_nxt;
    end
  end

  // CPU side: zero-stall hits, stall on miss or any non-idle state.
  always_comb begin
    busywait = !reset && (!w_idle || (w_req && !w_hit));
    readdata = (!reset && w_idle && read && w_hit) ?
               word_of(w_blk, w_wsel) : 32'd0;
  end

  assign flush_done = r_flush_done;

  // Memory side, driven from state and held CPU address only.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (r_state)
      S_WRITEBACK: begin
        mem_write     = 1'b1;
        mem_address   = {w_line_tag, w_idx};
        mem_writedata = w_blk;
      end
      S_ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = address[31:IDX_LSB];
      end
      S_FLUSH_WB: begin
        mem_write     = 1'b1;
        mem_address   = {w_line_tag, r_scan_idx};
        mem_writedata = w_blk;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 3-cycle memory model.
// Expected values are hand-derived from the address split and memory image.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic         clk;
  logic         reset;
  logic         read;
  logic         write;
  logic [31:0]  address;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         busywait;
  logic         flush;
  logic         flush_done;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  dcache_controller dut (
    .clk           (clk),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .flush         (flush),
    .flush_done    (flush_done),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: block a word w = {a[23:0], 6'b0, w}; block 4 is special.
  logic         mem_init;
  logic [127:0] mem_q   [256];
  logic         wvalid  [256];
  int           mcnt;
  logic         overlap;
  logic [27:0]  rd_addr_q[$];
  logic [27:0]  wr_addr_q[$];
  logic [127:0] wr_data_q[$];

  function automatic logic [127:0] dflt(input logic [27:0] a);
    logic [127:0] b;
    b = '0;
    if (a == 28'h4) begin
      b = {32'hD, 32'hC, 32'hB, 32'hA};
    end else begin
      for (int w = 0; w < 4; w++)
        b[w*32 +: 32] = {a[23:0], 6'b0, 2'(w)};
    end
    return b;
  endfunction

  assign mem_busywait = (mem_read || mem_write) && (mcnt != 3);

  always_comb begin
    mem_readdata = wvalid[mem_address[7:0]] ?
                   mem_q[mem_address[7:0]] : dflt(mem_address);
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) wvalid[i] <= 1'b0;
      mcnt    <= 0;
      overlap <= 1'b0;
    end else begin
      if (mem_read && mem_write) overlap <= 1'b1;
      if (mem_read || mem_write) begin
        if (!mem_busywait) begin
          mcnt <= 0;
          if (mem_write) begin
            mem_q[mem_address[7:0]]  <= mem_writedata;
            wvalid[mem_address[7:0]] <= 1'b1;
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_writedata);
          end else begin
            rd_addr_q.push_back(mem_address);
          end
        end else begin
          mcnt <= mcnt + 1;
        end
      end else begin
        mcnt <= 0;
      end
    end
  end

  int n_pass;
  int n_total;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic clr_log();
    rd_addr_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the access completes.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdat, output int stall);
    int  n;
    bit  done;
    read = rd; write = wr; address = a; writedata = wd;
    n = 0; done = 0; rdat = '0;
    while (!done && n < 60) begin
      @(negedge clk);
      if (!busywait) begin
        done = 1;
        rdat = readdata;
      end else begin
        n++;
      end
    end
    if (!done) check("access_timeout", 0, 1);
    stall = n;
    @(posedge clk); #1;
    read = 0; write = 0;
  endtask

  logic [31:0] rd;
  int          st;
  int          nbusy, nfree, ndone, t_done, t_hit, n;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1; read = 0; write = 0; flush = 0;
    address = 0; writedata = 0; mem_init = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busywait",   busywait,      0);
    check("rst_flush_done", flush_done,    0);
    check("rst_mem_read",   mem_read,      0);
    check("rst_mem_write",  mem_write,     0);
    check("rst_mem_addr",   mem_address,   0);
    check("rst_mem_wdata",  mem_writedata, 0);
    check("rst_readdata",   readdata,      0);
    reset = 0; mem_init = 0;
    clr_log();

    // Cold read miss on 0x40 (index 4, tag 0).
    access(1, 0, 32'h40, 0, rd, st);
    check("cold_rdata",  rd, 32'hA);
    check("cold_stall",  st, 5);
    check("cold_nrd",    rd_addr_q.size(), 1);
    check("cold_rdaddr", rd_addr_q[0], 28'h4);
    check("cold_nwr",    wr_addr_q.size(), 0);
    access(1, 0, 32'h44, 0, rd, st);
    check("hit44_rdata", rd, 32'hB);
    check("hit44_stall", st, 0);

    // Write hit, then conflicting read forces dirty eviction.
    clr_log();
    access(0, 1, 32'h40, 32'h1234_5678, rd, st);
    check("whit_stall", st, 0);
    access(1, 0, 32'hC0, 0, rd, st);
    check("evict_rdata",  rd, 32'h0000_0C00);
    check("evict_stall",  st, 9);
    check("evict_nwr",    wr_addr_q.size(), 1);
    check("evict_wraddr", wr_addr_q[0], 28'h4);
    check("evict_wrdata", wr_data_q[0],
          {32'hD, 32'hC, 32'hB, 32'h1234_5678});
    check("evict_rdaddr", rd_addr_q[0], 28'hC);

    // Write miss into clean victim line 0.
    clr_log();
    access(0, 1, 32'h100, 32'hCAFE_F00D, rd, st);
    check("wmiss_stall",  st, 5);
    check("wmiss_nwr",    wr_addr_q.size(), 0);
    check("wmiss_nrd",    rd_addr_q.size(), 1);
    check("wmiss_rdaddr", rd_addr_q[0], 28'h10);
    access(1, 0, 32'h100, 0, rd, st);
    check("wmiss_rdata", rd, 32'hCAFE_F00D);
    check("wmiss_hstall", st, 0);
    clr_log();
    access(1, 0, 32'h180, 0, rd, st);
    check("dirty0_stall",  st, 9);
    check("dirty0_wraddr", wr_addr_q[0], 28'h10);
    check("dirty0_word0",  wr_data_q[0][31:0], 32'hCAFE_F00D);

    // Flush with dirty lines at indices 1 and 6.
    access(0, 1, 32'h10, 32'h1111_1111, rd, st);
    check("fl_prep1", st, 5);
    access(0, 1, 32'h60, 32'h6666_6666, rd, st);
    check("fl_prep6", st, 5);
    clr_log();
    flush = 1;
    nbusy = 0; nfree = 0; ndone = 0; t_done = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (flush_done) begin
        ndone++;
        t_done = c;
      end
      if (c > 0 && ndone == 0) begin
        if (busywait) nbusy++;
        else nfree++;
      end
      @(posedge clk); #1;
      flush = (c == 2);
    end
    flush = 0;
    check("fl_ndone",  ndone, 1);
    check("fl_tdone",  t_done, 17);
    check("fl_nbusy",  nbusy, 16);
    check("fl_nfree",  nfree, 0);
    check("fl_nwr",    wr_addr_q.size(), 2);
    check("fl_wr0",    wr_addr_q[0], 28'h1);
    check("fl_wr1",    wr_addr_q[1], 28'h6);
    check("fl_data0",  wr_data_q[0],
          {32'h103, 32'h102, 32'h101, 32'h1111_1111});
    check("fl_data1",  wr_data_q[1],
          {32'h603, 32'h602, 32'h601, 32'h6666_6666});
    clr_log();
    access(1, 0, 32'h10, 0, rd, st);
    check("postfl_stall", st, 5);
    check("postfl_rdata", rd, 32'h1111_1111);
    check("postfl_nwr",   wr_addr_q.size(), 0);

    // Reset while ALLOCATE is waiting on memory.
    clr_log();
    read = 1; address = 32'h200;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (mem_read && mem_busywait) break;
      n++;
    end
    check("rst_alloc_seen", mem_read, 1);
    reset = 1;
    @(posedge clk); #1;
    check("rst_mid_mrd",   mem_read,    0);
    check("rst_mid_mwr",   mem_write,   0);
    check("rst_mid_busy",  busywait,    0);
    check("rst_mid_state", dut.r_state, S_IDLE);
    reset = 0; read = 0;
    access(1, 0, 32'h200, 0, rd, st);
    check("rst_remiss_stall", st, 5);
    check("rst_remiss_rdata", rd, 32'h0000_2000);
    check("rst_remiss_nrd",   rd_addr_q.size(), 1);

    // Flush pulse in the same cycle as a read miss.
    clr_log();
    read = 1; address = 32'h300; flush = 1;
    t_hit = -1; t_done = -1; ndone = 0; rd = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (read && !busywait && t_hit < 0) begin
        t_hit = c;
        rd = readdata;
      end
      if (flush_done) begin
        ndone++;
        t_done = c;
      end
      @(posedge clk); #1;
      flush = 0;
      if (t_hit >= 0) read = 0;
    end
    check("co_thit",  t_hit, 5);
    check("co_rdata", rd, 32'h0000_3000);
    check("co_ndone", ndone, 1);
    check("co_tdone", t_done, 14);
    check("co_rdadr", rd_addr_q[0], 28'h30);
    check("co_nwr",   wr_addr_q.size(), 0);
    access(1, 0, 32'h300, 0, rd, st);
    check("co_after_stall", st, 5);

    check("no_rd_wr_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
